// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and pending-write scoreboard for the register file write port.
// Define WB_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_SRC-1:0]           src_req,
    input  logic [5*NUM_SRC-1:0]         src_addr,
    input  logic [DATA_WIDTH*NUM_SRC-1:0] src_data,
    output logic [NUM_SRC-1:0]           src_grant,
    output logic                         wb_enable,
    output logic [4:0]                   wb_address,
    output logic [DATA_WIDTH-1:0]        wb_data,
    input  logic                         issue_valid,
    input  logic [4:0]                   issue_rd,
    input  logic                         flush,
    input  logic [4:0]                   rs_query,
    input  logic [4:0]                   rt_query,
    output logic                         rs_busy,
    output logic                         rt_busy
);

    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_SRC - 1);

    // Handshake: a source holds req/addr/data stable until a rising edge where its
    // grant is high; the write is transferred at exactly that edge (req acts as valid,
    // grant as ready), and the source may present a new write in the next cycle.
    logic [NUM_SRC-1:0]    grant;
    logic                  grant_any;
    logic [4:0]            grant_addr;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [31:0]           pending;
    logic [31:0]           pending_next;

`ifdef WB_ARB_FIXED_PRIORITY_EN
    always_comb begin
        grant = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
        if (reset) grant = '0;
    end
`else
    logic [PW-1:0] last_ptr;
    logic [PW-1:0] idx;
    logic [PW-1:0] grant_idx;

    // Walk the sources starting one past the last winner, wrapping at NUM_SRC-1.
    always_comb begin
        grant     = '0;
        grant_idx = last_ptr;
        idx       = last_ptr;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (idx == LAST_IDX) ? '0 : idx + PW'(1);
            if (grant == '0 && src_req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
        if (reset) grant = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_ptr <= LAST_IDX;
        end else if (grant_any) begin
            last_ptr <= grant_idx;
        end
    end
`endif

    assign grant_any = |grant;
    assign src_grant = grant;

    always_comb begin
        grant_addr = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                grant_addr = grant_addr | src_addr[5*i +: 5];
                grant_data = grant_data | src_data[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // Flush first, then retire the granted write, then a newer producer re-marks its register.
    always_comb begin
        pending_next = flush ? '0 : pending;
        if (grant_any) pending_next[grant_addr] = 1'b0;
        if (issue_valid && issue_rd != 5'd0) pending_next[issue_rd] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_enable  <= 1'b0;
            wb_address <= '0;
            wb_data    <= '0;
            pending    <= '0;
        end else begin
            pending <= pending_next;
            if (grant_any) begin
                wb_enable  <= (grant_addr != 5'd0);
                wb_address <= grant_addr;
                wb_data    <= grant_data;
            end else begin
                wb_enable  <= 1'b0;
            end
        end
    end

    assign rs_busy = pending[rs_query] & (rs_query != 5'd0);
    assign rt_busy = pending[rt_query] & (rt_query != 5'd0);

endmodule
